alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single fixed-latency ALU datapath (controlled by a `p_alu::s_control` word) between `N_REQ` requesters. Requesters use valid/ready handshakes, and a round-robin policy grants them. Each requester may have one operation in flight. Its result is held in a per-requester response register until it is consumed. The block sits between the issue stages and the shared ALU instance and is the only driver of the ALU inputs.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 32: operand and result width.
- `ALU_LATENCY`, default 2: cycles from `alu_valid` to `alu_result` valid, 1..4.
- `IDX_W`, default `$clog2(N_REQ)`: tag width (derived, not overridable).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  request valid per requester.
- `req_ready`  out  N_REQ  request accepted (grant), combinational.
- `req_ctrl`  in  N_REQ x s_control  ALU control word per requester.
- `req_a`, `req_b`  in  N_REQ x WIDTH  operands.
- `rsp_valid`  out  N_REQ  response held.
- `rsp_ready`  in  N_REQ  response consumed.
- `rsp_data`  out  N_REQ x WIDTH  result.
- `rsp_err`  out  N_REQ  op was `CORE_OP_INVALID`.
- `alu_valid`  out  1  ALU issue strobe, registered.
- `alu_ctrl`  out  s_control  registered control word.
- `alu_a`, `alu_b`  out  WIDTH  registered operands.
- `alu_result`  in  WIDTH  ALU result, valid `ALU_LATENCY` cycles after `alu_valid`.

## Operation
- **Eligibility**
  - Requester i is eligible if `req_valid[i]`, and either `!outstanding[i]` or (`rsp_valid[i] && rsp_ready[i]`) holds in the same cycle.
- **Arbitration**
  - At most one grant per cycle.
  - Round-robin pointer `last`: priority search starts at `last+1` and wraps modulo `N_REQ`.
  - `last` updates to the granted index only on a grant.
  - Reset value of `last` is `N_REQ-1`, so requester 0 has first priority.
- **Grant effects** (requester g, cycle T):
  - `req_ready[g]`=1 and all other `req_ready` bits are 0.
  - Set `outstanding[g]`.
  - Register ctrl/a/b into `alu_*` for cycle T+1.
  - Push tag {valid, g, err} into a tag shift register of depth `ALU_LATENCY`.
- **Invalid op** (`req_ctrl.op == CORE_OP_INVALID`):
  - The request is granted and consumes a slot.
  - `alu_valid` stays 0 in T+1 (ALU bubble) and the tag carries err=1.
  - The response returns at the normal latency with `rsp_data`=0 and `rsp_err`=1.
- **Retire**
  - When the tag-pipe tail is valid, capture `alu_result` (or 0 if err) into `rsp_data[g]`.
  - Set `rsp_valid[g]` and `rsp_err[g]` on the next edge.
- **Response handshake**
  - `rsp_valid[i] && rsp_ready[i]` clears `rsp_valid[i]` and `outstanding[i]`.
  - A same-cycle re-grant to i re-sets `outstanding[i]`; set has priority over clear.
- **Held registers**
  - `rsp_data`/`rsp_err` hold their value while `rsp_valid` is high.
  - The ALU outputs hold their last value when `alu_valid`=0.
- **Retire collision**: a retire into slot i can never collide with held data, because one-outstanding guarantees `rsp_valid[i]`=0 at retire.

## Timing
- **Reset values**:
  - `alu_valid`=0; `alu_ctrl`/`alu_a`/`alu_b`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `outstanding`=0, tag pipe all invalid, `last`=`N_REQ-1`.
  - `req_ready`=0 while `rst_n`=0.
- **Latency**: handshake cycle T, `alu_valid` in T+1, `alu_result` sampled in T+1+ALU_LATENCY, `rsp_valid` high in T+2+ALU_LATENCY. With the default latency, a response appears 4 cycles after the grant.
- **Throughput**
  - One issue per cycle across requesters.
  - Per requester, one op per (ALU_LATENCY+2) cycles minimum: a re-grant is possible in the same cycle the response is consumed.
- **Combinational paths**: `req_ready` depends combinationally on `req_valid`, `rsp_ready`, and state. No path from `alu_result` to any output.
- **Reset mid-operation**: all in-flight tags are discarded. ALU results arriving after reset release are ignored, because the tag pipe is invalid.
- **Response stall**: a requester that never asserts `rsp_ready` only blocks itself. The others continue to be granted.

## Test plan
- **Reset**: assert `rst_n`=0 mid-traffic, release -> all outputs at reset values. A stale `alu_result`=0xDEAD arriving 2 cycles later produces no `rsp_valid`.
- **Single op**: requester 1 issues ADD, a=5, b=7, at cycle 0 -> `alu_valid` at 1 with a=5/b=7; `rsp_valid[1]` at cycle 4 with `rsp_data`=12 and `rsp_err`=0.
- **Round-robin**: all 4 requesters valid continuously, with `rsp_ready`=1 -> grant order 0,1,2,3,0,… The sequence is one grant per cycle, limited by per-requester latency, and no requester is starved.
- **Backpressure**: requester 2 holds `rsp_ready`=0 -> `req_ready[2]` stays 0 while the others keep being granted. Raising `rsp_ready[2]` with `req_valid[2]`=1 re-grants requester 2 in that same cycle.
- **Invalid op**: requester 0 issues op=`CORE_OP_INVALID` -> `alu_valid`=0 in cycle 1; `rsp_valid[0]` at cycle 4 with `rsp_data`=0 and `rsp_err`=1.
- **Latency sweep**: `ALU_LATENCY`=1 and `ALU_LATENCY`=4 with a back-to-back mix across requesters -> every response arrives at grant+L+2, correctly tagged, with no cross-requester data swap.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one fixed-latency ALU between N_REQ valid/ready requesters
// using round-robin grants, a tag pipe that follows each op, and per-requester response registers.
package p_alu;
   typedef enum logic [2:0] {
      CORE_OP_ADD     = 3'd0,
      CORE_OP_SUB     = 3'd1,
      CORE_OP_AND     = 3'd2,
      CORE_OP_OR      = 3'd3,
      CORE_OP_XOR     = 3'd4,
      CORE_OP_SLL     = 3'd5,
      CORE_OP_SRL     = 3'd6,
      CORE_OP_INVALID = 3'd7
   } core_op_e;

   typedef struct packed {
      core_op_e op;
      logic     is_signed;
   } s_control;
endpackage

module alu_arbiter #(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 32,
   parameter int ALU_LATENCY = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_REQ-1:0]                req_valid,
   output logic [N_REQ-1:0]                req_ready,
   input  p_alu::s_control [N_REQ-1:0]     req_ctrl,
   input  logic [N_REQ-1:0][WIDTH-1:0]     req_a,
   input  logic [N_REQ-1:0][WIDTH-1:0]     req_b,
   output logic [N_REQ-1:0]                rsp_valid,
   input  logic [N_REQ-1:0]                rsp_ready,
   output logic [N_REQ-1:0][WIDTH-1:0]     rsp_data,
   output logic [N_REQ-1:0]                rsp_err,
   output logic                            alu_valid,
   output p_alu::s_control                 alu_ctrl,
   output logic [WIDTH-1:0]                alu_a,
   output logic [WIDTH-1:0]                alu_b,
   input  logic [WIDTH-1:0]                alu_result
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]                  outstanding_q, outstanding_d;
   logic [IDX_W-1:0]                  last_q, last_d;
   logic [N_REQ-1:0]                  hs_s, eligible_s, grant_s;
   logic                              grant_vld_s, grant_inv_s;
   logic [IDX_W-1:0]                  grant_idx_s;

   logic                              alu_valid_q, alu_valid_d;
   p_alu::s_control                   alu_ctrl_q, alu_ctrl_d;
   logic [WIDTH-1:0]                  alu_a_q, alu_a_d, alu_b_q, alu_b_d;

   logic                              iss_v_q, iss_v_d, iss_err_q, iss_err_d;
   logic [IDX_W-1:0]                  iss_idx_q, iss_idx_d;
   logic [ALU_LATENCY-1:0]            tag_v_q, tag_v_d, tag_err_q, tag_err_d;
   logic [ALU_LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;

   logic [N_REQ-1:0]                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [N_REQ-1:0][WIDTH-1:0]       rsp_data_q, rsp_data_d;

   // A response consumed this cycle frees its slot for a same-cycle re-grant.
   assign hs_s       = rsp_valid_q & rsp_ready;
   assign eligible_s = rst_n ? (req_valid & (~outstanding_q | hs_s)) : {N_REQ{1'b0}};

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand        = last_q;
      grant_vld_s = 1'b0;
      grant_idx_s = last_q;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(last_q) + k) % N_REQ);
         if (!grant_vld_s && eligible_s[cand]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = cand;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   always_comb begin
      grant_s = {N_REQ{1'b0}};
      if (grant_vld_s) begin
         grant_s[grant_idx_s] = 1'b1;
      end else begin
         grant_s = {N_REQ{1'b0}};
      end
      grant_inv_s = grant_vld_s && (req_ctrl[grant_idx_s].op == p_alu::CORE_OP_INVALID);
   end

   assign req_ready = grant_s;

   // Issue side: an invalid op takes a slot but leaves an ALU bubble and holds the operands.
   always_comb begin
      outstanding_d = (outstanding_q & ~hs_s) | grant_s;
      last_d        = grant_vld_s ? grant_idx_s : last_q;
      alu_valid_d   = grant_vld_s & ~grant_inv_s;
      if (alu_valid_d) begin
         alu_ctrl_d = req_ctrl[grant_idx_s];
         alu_a_d    = req_a[grant_idx_s];
         alu_b_d    = req_b[grant_idx_s];
      end else begin
         alu_ctrl_d = alu_ctrl_q;
         alu_a_d    = alu_a_q;
         alu_b_d    = alu_b_q;
      end
      iss_v_d   = grant_vld_s;
      iss_idx_d = grant_idx_s;
      iss_err_d = grant_inv_s;
   end

   // Tag stage 0 lines up with the cycle after alu_valid; the tail lines up with alu_result.
   always_comb begin
      tag_v_d      = tag_v_q;
      tag_idx_d    = tag_idx_q;
      tag_err_d    = tag_err_q;
      tag_v_d[0]   = iss_v_q;
      tag_idx_d[0] = iss_idx_q;
      tag_err_d[0] = iss_err_q;
      for (int k = 1; k < ALU_LATENCY; k++) begin
         tag_v_d[k]   = tag_v_q[k-1];
         tag_idx_d[k] = tag_idx_q[k-1];
         tag_err_d[k] = tag_err_q[k-1];
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q & ~hs_s;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (tag_v_q[ALU_LATENCY-1] && (tag_idx_q[ALU_LATENCY-1] == IDX_W'(i))) begin
            rsp_valid_d[i] = 1'b1;
            rsp_err_d[i]   = tag_err_q[ALU_LATENCY-1];
            rsp_data_d[i]  = tag_err_q[ALU_LATENCY-1] ? {WIDTH{1'b0}} : alu_result;
         end else begin
            rsp_valid_d[i] = rsp_valid_d[i];
         end
      end
   end

   // Reset discards all in-flight tags, so late ALU results are never retired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= {N_REQ{1'b0}};
         last_q        <= IDX_W'(N_REQ - 1);
         alu_valid_q   <= 1'b0;
         alu_ctrl_q    <= '{op: p_alu::CORE_OP_ADD, is_signed: 1'b0};
         alu_a_q       <= {WIDTH{1'b0}};
         alu_b_q       <= {WIDTH{1'b0}};
         iss_v_q       <= 1'b0;
         iss_idx_q     <= {IDX_W{1'b0}};
         iss_err_q     <= 1'b0;
         tag_v_q       <= {ALU_LATENCY{1'b0}};
         tag_idx_q     <= {(ALU_LATENCY*IDX_W){1'b0}};
         tag_err_q     <= {ALU_LATENCY{1'b0}};
         rsp_valid_q   <= {N_REQ{1'b0}};
         rsp_data_q    <= {(N_REQ*WIDTH){1'b0}};
         rsp_err_q     <= {N_REQ{1'b0}};
      end else begin
         outstanding_q <= outstanding_d;
         last_q        <= last_d;
         alu_valid_q   <= alu_valid_d;
         alu_ctrl_q    <= alu_ctrl_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         iss_v_q       <= iss_v_d;
         iss_idx_q     <= iss_idx_d;
         iss_err_q     <= iss_err_d;
         tag_v_q       <= tag_v_d;
         tag_idx_q     <= tag_idx_d;
         tag_err_q     <= tag_err_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign alu_valid = alu_valid_q;
   assign alu_ctrl  = alu_ctrl_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: three arbiter copies (ALU latency 2, 1, 4), each with its own random
// traffic, an emulated ALU and a transaction-level reference model checked every cycle.
module tb_alu_arbiter;
   localparam int N     = 4;
   localparam int W     = 32;
   localparam int N_CYC = 800;

   logic clk = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int lat, input int cyc,
                      input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (L=%0d cycle %0d): got %0h, want %0h", name, lat, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] alu_f(input p_alu::s_control c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (c.op)
         p_alu::CORE_OP_ADD: return a + b;
         p_alu::CORE_OP_SUB: return a - b;
         p_alu::CORE_OP_AND: return a & b;
         p_alu::CORE_OP_OR:  return a | b;
         p_alu::CORE_OP_XOR: return a ^ b;
         p_alu::CORE_OP_SLL: return a << b[4:0];
         p_alu::CORE_OP_SRL: return a >> b[4:0];
         default:            return {W{1'b0}};
      endcase
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_lat
      localparam int L = (k == 0) ? 2 : ((k == 1) ? 1 : 4);

      logic                     rst_n, alu_valid;
      logic [N-1:0]             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
      p_alu::s_control [N-1:0]  req_ctrl;
      logic [N-1:0][W-1:0]      req_a, req_b, rsp_data;
      p_alu::s_control          alu_ctrl;
      logic [W-1:0]             alu_a, alu_b, alu_result;

      alu_arbiter #(.N_REQ(N), .WIDTH(W), .ALU_LATENCY(L)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
         .req_a(req_a), .req_b(req_b),
         .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
         .alu_valid(alu_valid), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
         .alu_result(alu_result)
      );

      initial begin : run
         int cyc, g, cand, p_new;
         int rr_cnt[N];
         int bp_cnt[N];
         logic [N-1:0] hv, mask, exp_rdy, out_m, rspv_m, rspe_m;
         logic [N-1:0][W-1:0] rspd_m;
         logic alv_m, err;
         p_alu::s_control alc_m;
         logic [W-1:0] ala_m, alb_m;
         int q_due[$];
         int q_idx[$];
         logic [W-1:0] q_dat[$];
         logic q_err[$];
         int a_due[$];
         logic [W-1:0] a_val[$];

         rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_ctrl = '0;
         req_a = '0; req_b = '0; alu_result = '0;
         hv = '0; out_m = '0; rspv_m = '0; rspe_m = '0; rspd_m = '0;
         alv_m = 1'b0; alc_m = '0; ala_m = '0; alb_m = '0;
         g = N - 1;
         cand = N - 1;
         for (int i = 0; i < N; i++) begin
            rr_cnt[i] = 0;
            bp_cnt[i] = 0;
         end
         @(posedge clk); #1;
         for (cyc = 0; cyc < N_CYC; cyc++) begin
            rst_n = (cyc >= 4) && !(cyc >= 560 && cyc < 563);
            mask  = '1;
            if (cyc < 22) begin
               p_new = 0; rsp_ready = '1;
            end else if (cyc < 300 || (cyc > 500 && cyc < N_CYC - 30)) begin
               p_new = 40;
               for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 99) < 70);
            end else if (cyc < 400) begin
               p_new = 100; rsp_ready = '1;
            end else if (cyc < 500) begin
               p_new = 100; rsp_ready = 4'b1011;
            end else if (cyc == 500) begin
               p_new = 0; rsp_ready = '1; mask = 4'b0100;
            end else begin
               p_new = 0; rsp_ready = '1;
            end
            if (cyc == 6) begin
               hv[1] = 1'b1; req_ctrl[1].op = p_alu::CORE_OP_ADD; req_ctrl[1].is_signed = 1'b0;
               req_a[1] = 32'd5; req_b[1] = 32'd7;
            end
            if (cyc == 14) begin
               hv[0] = 1'b1; req_ctrl[0].op = p_alu::CORE_OP_INVALID; req_ctrl[0].is_signed = 1'b0;
               req_a[0] = 32'd9; req_b[0] = 32'd3;
            end
            for (int i = 0; i < N; i++) begin
               if (!hv[i] && ($urandom_range(0, 99) < p_new)) begin
                  hv[i] = 1'b1;
                  req_ctrl[i].op = p_alu::core_op_e'($urandom_range(0, 7));
                  req_ctrl[i].is_signed = 1'($urandom_range(0, 1));
                  req_a[i] = $urandom();
                  req_b[i] = $urandom();
               end
            end
            req_valid = hv & mask;
            // emulated ALU: result only on its due cycle, junk otherwise
            while (a_due.size() > 0 && a_due[0] < cyc) begin
               void'(a_due.pop_front()); void'(a_val.pop_front());
            end
            if (a_due.size() > 0 && a_due[0] == cyc) begin
               alu_result = a_val[0];
               void'(a_due.pop_front()); void'(a_val.pop_front());
            end else if (cyc >= 563 && cyc < 568) begin
               alu_result = 32'hDEAD;
            end else begin
               alu_result = $urandom();
            end

            @(negedge clk);
            if (!rst_n) begin
               out_m = '0; rspv_m = '0; rspe_m = '0; rspd_m = '0;
               alv_m = 1'b0; alc_m = '0; ala_m = '0; alb_m = '0; g = N - 1;
               q_due.delete(); q_idx.delete(); q_dat.delete(); q_err.delete();
            end
            // g carries the round-robin pointer between cycles; grant found below
            cand = g;
            g = -1;
            exp_rdy = '0;
            if (rst_n) begin
               for (int j = 1; j <= N; j++) begin
                  if (g < 0 && req_valid[(cand + j) % N] &&
                      (!out_m[(cand + j) % N] || (rspv_m[(cand + j) % N] && rsp_ready[(cand + j) % N])))
                     g = (cand + j) % N;
               end
               if (g >= 0) exp_rdy[g] = 1'b1;
            end

            chk("req_ready", L, cyc, 64'(req_ready), 64'(exp_rdy));
            chk("rsp_valid", L, cyc, 64'(rsp_valid), 64'(rspv_m));
            chk("rsp_err",   L, cyc, 64'(rsp_err),   64'(rspe_m));
            for (int i = 0; i < N; i++) chk("rsp_data", L, cyc, 64'(rsp_data[i]), 64'(rspd_m[i]));
            chk("alu_valid", L, cyc, 64'(alu_valid), 64'(alv_m));
            chk("alu_ctrl",  L, cyc, 64'(alu_ctrl),  64'(alc_m));
            chk("alu_a",     L, cyc, 64'(alu_a),     64'(ala_m));
            chk("alu_b",     L, cyc, 64'(alu_b),     64'(alb_m));

            if (cyc == 6) chk("add_grant", L, cyc, 64'(req_ready), 64'h2);
            if (cyc == 7) begin
               chk("add_issue_valid", L, cyc, 64'(alu_valid), 64'h1);
               chk("add_issue_a", L, cyc, 64'(alu_a), 64'd5);
               chk("add_issue_b", L, cyc, 64'(alu_b), 64'd7);
            end
            if (cyc == 6 + L + 1) chk("add_not_early", L, cyc, 64'(rsp_valid[1]), 64'h0);
            if (cyc == 6 + L + 2) begin
               chk("add_rsp_valid", L, cyc, 64'(rsp_valid[1]), 64'h1);
               chk("add_rsp_data", L, cyc, 64'(rsp_data[1]), 64'd12);
               chk("add_rsp_err", L, cyc, 64'(rsp_err[1]), 64'h0);
            end
            if (cyc == 14) chk("inv_grant", L, cyc, 64'(req_ready), 64'h1);
            if (cyc == 15) begin
               chk("inv_bubble", L, cyc, 64'(alu_valid), 64'h0);
               chk("inv_hold_a", L, cyc, 64'(alu_a), 64'd5);
            end
            if (cyc == 14 + L + 2) begin
               chk("inv_rsp_valid", L, cyc, 64'(rsp_valid[0]), 64'h1);
               chk("inv_rsp_data", L, cyc, 64'(rsp_data[0]), 64'h0);
               chk("inv_rsp_err", L, cyc, 64'(rsp_err[0]), 64'h1);
            end
            if (cyc == 400)
               for (int i = 0; i < N; i++) chk("rr_no_starve", L, cyc, 64'(rr_cnt[i] >= 12), 64'h1);
            if (cyc == 500) begin
               chk("bp_regrant", L, cyc, 64'(req_ready), 64'h4);
               chk("bp_stalled_grants", L, cyc, 64'(bp_cnt[2]), 64'h0);
               chk("bp_others_0", L, cyc, 64'(bp_cnt[0] >= 8), 64'h1);
               chk("bp_others_3", L, cyc, 64'(bp_cnt[3] >= 8), 64'h1);
            end
            if (cyc == 561) begin
               chk("rst_req_ready", L, cyc, 64'(req_ready), 64'h0);
               chk("rst_rsp_valid", L, cyc, 64'(rsp_valid), 64'h0);
               chk("rst_alu_valid", L, cyc, 64'(alu_valid), 64'h0);
               chk("rst_alu_a", L, cyc, 64'(alu_a), 64'h0);
            end
            if (cyc >= 563 && cyc <= 564 + L) chk("stale_result", L, cyc, 64'(rsp_valid), 64'h0);

            if (alu_valid) begin
               a_due.push_back(cyc + L);
               a_val.push_back(alu_f(alu_ctrl, alu_a, alu_b));
            end
            if (rst_n) begin
               for (int i = 0; i < N; i++)
                  if (rspv_m[i] && rsp_ready[i]) begin
                     rspv_m[i] = 1'b0;
                     out_m[i]  = 1'b0;
                  end
               alv_m = 1'b0;
               if (g >= 0) begin
                  out_m[g] = 1'b1;
                  hv[g]    = 1'b0;
                  err = (req_ctrl[g].op == p_alu::CORE_OP_INVALID);
                  if (!err) begin
                     alv_m = 1'b1; alc_m = req_ctrl[g]; ala_m = req_a[g]; alb_m = req_b[g];
                  end
                  q_due.push_back(cyc + L + 2);
                  q_idx.push_back(g);
                  q_dat.push_back(err ? {W{1'b0}} : alu_f(req_ctrl[g], req_a[g], req_b[g]));
                  q_err.push_back(err);
                  if (cyc >= 300 && cyc < 400) rr_cnt[g]++;
                  if (cyc >= 420 && cyc < 500) bp_cnt[g]++;
               end else begin
                  g = cand;
               end
               if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
                  rspv_m[q_idx[0]] = 1'b1;
                  rspd_m[q_idx[0]] = q_dat[0];
                  rspe_m[q_idx[0]] = q_err[0];
                  void'(q_due.pop_front()); void'(q_idx.pop_front());
                  void'(q_dat.pop_front()); void'(q_err.pop_front());
               end
            end else begin
               g = N - 1;
            end
            @(posedge clk); #1;
         end
         n_done++;
      end
   end

   initial begin
      repeat (N_CYC + 20) @(posedge clk);
      chk("all_lanes_done", 0, N_CYC, 64'(n_done), 64'd3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
